// File: rtl/matmul_tile_sched_pkg.sv
// Shared constants and state encoding for the matmul tile scheduler.
// Used by the scheduler top and its address generator.
package matmul_tile_sched_pkg;

   localparam int MAT_MUL_SIZE = 4;
   localparam int AWIDTH       = 10;
   localparam int DIM_WIDTH    = 8;
   localparam int TC_WIDTH     = 2*DIM_WIDTH + 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_GAP    = 3'd3,
      S_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/matmul_tile_sched_tile_addr_gen.sv
// Tile index counters and incremental A/B/C address registers.
// Loop order: k innermost, then n, then m; no multipliers.
module tile_addr_gen #(
   parameter int MAT_MUL_SIZE = 4,
   parameter int AWIDTH       = 10,
   parameter int DIM_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 load_i,
   input  logic                 adv_i,
   input  logic [DIM_WIDTH-1:0] num_m_i,
   input  logic [DIM_WIDTH-1:0] num_n_i,
   input  logic [DIM_WIDTH-1:0] num_k_i,
   input  logic [AWIDTH-1:0]    base_a_i,
   input  logic [AWIDTH-1:0]    base_b_i,
   input  logic [AWIDTH-1:0]    base_c_i,
   input  logic [AWIDTH-1:0]    stride_a_i,
   input  logic [AWIDTH-1:0]    stride_b_i,
   input  logic [AWIDTH-1:0]    stride_c_i,
   output logic [AWIDTH-1:0]    addr_a_o,
   output logic [AWIDTH-1:0]    addr_b_o,
   output logic [AWIDTH-1:0]    addr_c_o,
   output logic                 acc_o,
   output logic                 last_o
);

   import matmul_tile_sched_pkg::*;

   localparam logic [AWIDTH-1:0]    STEP = AWIDTH'(MAT_MUL_SIZE);
   localparam logic [DIM_WIDTH-1:0] ONE  = DIM_WIDTH'(1);

   logic [DIM_WIDTH-1:0] k_q, k_d, n_q, n_d, m_q, m_d;
   logic [DIM_WIDTH-1:0] kl_q, kl_d, nl_q, nl_d, ml_q, ml_d;
   logic [AWIDTH-1:0]    bb_q, bb_d;
   logic [AWIDTH-1:0]    sa_q, sa_d, sb_q, sb_d, sc_q, sc_d;
   logic [AWIDTH-1:0]    rowa_q, rowa_d, rowc_q, rowc_d;
   logic [AWIDTH-1:0]    colb_q, colb_d;
   logic [AWIDTH-1:0]    a_q, a_d, b_q, b_d, c_q, c_d;
   logic                 acc_q, acc_d;

   // Load on run start, otherwise step to the next tile on advance.
   always_comb begin
      k_d    = k_q;
      n_d    = n_q;
      m_d    = m_q;
      kl_d   = kl_q;
      nl_d   = nl_q;
      ml_d   = ml_q;
      bb_d   = bb_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      sc_d   = sc_q;
      rowa_d = rowa_q;
      rowc_d = rowc_q;
      colb_d = colb_q;
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      acc_d  = acc_q;
      if (load_i) begin
         k_d    = '0;
         n_d    = '0;
         m_d    = '0;
         kl_d   = num_k_i - ONE;
         nl_d   = num_n_i - ONE;
         ml_d   = num_m_i - ONE;
         bb_d   = base_b_i;
         sa_d   = stride_a_i;
         sb_d   = stride_b_i;
         sc_d   = stride_c_i;
         rowa_d = base_a_i;
         rowc_d = base_c_i;
         colb_d = base_b_i;
         a_d    = base_a_i;
         b_d    = base_b_i;
         c_d    = base_c_i;
         acc_d  = 1'b0;
      end else if (adv_i) begin
         if (k_q != kl_q) begin
            k_d   = k_q + ONE;
            a_d   = a_q + STEP;
            b_d   = b_q + STEP;
            acc_d = 1'b1;
         end else if (n_q != nl_q) begin
            k_d    = '0;
            n_d    = n_q + ONE;
            a_d    = rowa_q;
            colb_d = colb_q + sb_q;
            b_d    = colb_q + sb_q;
            c_d    = c_q + STEP;
            acc_d  = 1'b0;
         end else if (m_q != ml_q) begin
            k_d    = '0;
            n_d    = '0;
            m_d    = m_q + ONE;
            rowa_d = rowa_q + sa_q;
            rowc_d = rowc_q + sc_q;
            a_d    = rowa_q + sa_q;
            colb_d = bb_q;
            b_d    = bb_q;
            c_d    = rowc_q + sc_q;
            acc_d  = 1'b0;
         end
      end
   end

   // Index, stride and address registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         k_q    <= '0;
         n_q    <= '0;
         m_q    <= '0;
         kl_q   <= '0;
         nl_q   <= '0;
         ml_q   <= '0;
         bb_q   <= '0;
         sa_q   <= '0;
         sb_q   <= '0;
         sc_q   <= '0;
         rowa_q <= '0;
         rowc_q <= '0;
         colb_q <= '0;
         a_q    <= '0;
         b_q    <= '0;
         c_q    <= '0;
         acc_q  <= 1'b0;
      end else begin
         k_q    <= k_d;
         n_q    <= n_d;
         m_q    <= m_d;
         kl_q   <= kl_d;
         nl_q   <= nl_d;
         ml_q   <= ml_d;
         bb_q   <= bb_d;
         sa_q   <= sa_d;
         sb_q   <= sb_d;
         sc_q   <= sc_d;
         rowa_q <= rowa_d;
         rowc_q <= rowc_d;
         colb_q <= colb_d;
         a_q    <= a_d;
         b_q    <= b_d;
         c_q    <= c_d;
         acc_q  <= acc_d;
      end
   end

   assign addr_a_o = a_q;
   assign addr_b_o = b_q;
   assign addr_c_o = c_q;
   assign acc_o    = acc_q;
   assign last_o   = (k_q == kl_q) && (n_q == nl_q) && (m_q == ml_q);

endmodule

// File: rtl/matmul_tile_sched.sv
// Run-level FSM sequencing the 4x4 matmul over an M x N x K tile grid.
// Optional perf counters behind macro TILE_SCHED_PERF_EN.
module matmul_tile_sched #(
   parameter int MAT_MUL_SIZE = matmul_tile_sched_pkg::MAT_MUL_SIZE,
   parameter int AWIDTH       = matmul_tile_sched_pkg::AWIDTH,
   parameter int DIM_WIDTH    = matmul_tile_sched_pkg::DIM_WIDTH
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     abort,
   input  logic [DIM_WIDTH-1:0]     num_m_tiles,
   input  logic [DIM_WIDTH-1:0]     num_n_tiles,
   input  logic [DIM_WIDTH-1:0]     num_k_tiles,
   input  logic [AWIDTH-1:0]        base_a,
   input  logic [AWIDTH-1:0]        base_b,
   input  logic [AWIDTH-1:0]        base_c,
   input  logic [AWIDTH-1:0]        stride_a,
   input  logic [AWIDTH-1:0]        stride_b,
   input  logic [AWIDTH-1:0]        stride_c,
   output logic                     start_mat_mul,
   input  logic                     done_mat_mul,
   output logic [AWIDTH-1:0]        address_mat_a,
   output logic [AWIDTH-1:0]        address_mat_b,
   output logic [AWIDTH-1:0]        address_mat_c,
   output logic                     accumulate,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err,
`ifdef TILE_SCHED_PERF_EN
   output logic [31:0]              perf_cycles,
   output logic [31:0]              perf_wait,
`endif
   output logic [2*DIM_WIDTH+7:0]   tile_count
);

   import matmul_tile_sched_pkg::*;

   localparam int TCW = 2*DIM_WIDTH + 8;

   state_e         state_q, state_d;
   logic           start_q, start_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [TCW-1:0] cnt_q, cnt_d;
   logic           load, adv, last;
   logic           zero_dim;

   assign zero_dim = (num_m_tiles == '0) || (num_n_tiles == '0) ||
                     (num_k_tiles == '0);

   // Next-state and registered-output logic; abort overrides everything.
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      adv     = 1'b0;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         start_d = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  load  = 1'b1;
                  cnt_d = '0;
                  if (zero_dim) begin
                     err_d   = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     busy_d  = 1'b1;
                     state_d = S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               start_d = 1'b1;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (done_mat_mul) begin
                  start_d = 1'b0;
                  cnt_d   = cnt_q + TCW'(1);
                  state_d = S_GAP;
               end
            end
            S_GAP: begin
               if (last) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  adv     = 1'b1;
                  state_d = S_LAUNCH;
               end
            end
            S_DONE: begin
               start_d = 1'b0;
               if (!start) begin
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   tile_addr_gen #(
      .MAT_MUL_SIZE (MAT_MUL_SIZE),
      .AWIDTH       (AWIDTH),
      .DIM_WIDTH    (DIM_WIDTH)
   ) u_addr (
      .clk        (clk),
      .resetn     (resetn),
      .load_i     (load),
      .adv_i      (adv),
      .num_m_i    (num_m_tiles),
      .num_n_i    (num_n_tiles),
      .num_k_i    (num_k_tiles),
      .base_a_i   (base_a),
      .base_b_i   (base_b),
      .base_c_i   (base_c),
      .stride_a_i (stride_a),
      .stride_b_i (stride_b),
      .stride_c_i (stride_c),
      .addr_a_o   (address_mat_a),
      .addr_b_o   (address_mat_b),
      .addr_c_o   (address_mat_c),
      .acc_o      (accumulate),
      .last_o     (last)
   );

   assign start_mat_mul = start_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign cfg_err       = err_q;
   assign tile_count    = cnt_q;

`ifdef TILE_SCHED_PERF_EN
   logic [31:0] pc_q, pw_q;

   // Saturating busy-cycle and wait-cycle counters, cleared on run start.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q <= '0;
         pw_q <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         pc_q <= '0;
         pw_q <= '0;
      end else begin
         if (busy_q && (pc_q != '1)) pc_q <= pc_q + 32'd1;
         if ((state_q == S_WAIT) && (pw_q != '1)) pw_q <= pw_q + 32'd1;
      end
   end

   assign perf_cycles = pc_q;
   assign perf_wait   = pw_q;
`endif

endmodule

// File: tb/tb_matmul_tile_sched.sv
// Directed and randomized checks of matmul_tile_sched against a
// loop-nest reference model and a simple matmul responder.
module tb_matmul_tile_sched;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  nm, nn, nk;
   logic [9:0]  ba, bb, bc, sa, sb, sc;
   logic        smm;
   logic        dmm;
   logic [9:0]  aa, ab, ac;
   logic        acc, busy, done, err;
   logic [23:0] tc;
`ifdef TILE_SCHED_PERF_EN
   logic [31:0] pcyc, pwait;
`endif

   int total = 0;
   int bad = 0;
   int lat = 1;
   int unstable = 0;

   typedef struct packed {
      logic [9:0] a;
      logic [9:0] b;
      logic [9:0] c;
      logic       acc;
   } tile_t;

   tile_t got_q[$];
   tile_t exp_q[$];

   always #5 clk = ~clk;

   matmul_tile_sched dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .abort         (abort),
      .num_m_tiles   (nm),
      .num_n_tiles   (nn),
      .num_k_tiles   (nk),
      .base_a        (ba),
      .base_b        (bb),
      .base_c        (bc),
      .stride_a      (sa),
      .stride_b      (sb),
      .stride_c      (sc),
      .start_mat_mul (smm),
      .done_mat_mul  (dmm),
      .address_mat_a (aa),
      .address_mat_b (ab),
      .address_mat_c (ac),
      .accumulate    (acc),
      .busy          (busy),
      .done          (done),
      .cfg_err       (err),
`ifdef TILE_SCHED_PERF_EN
      .perf_cycles   (pcyc),
      .perf_wait     (pwait),
`endif
      .tile_count    (tc)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Matmul stand-in: records each tile on start rise, answers after lat.
   initial begin : resp
      tile_t cur;
      int    w;
      logic  prev;
      dmm  = 1'b0;
      w    = -1;
      prev = 1'b0;
      cur  = '0;
      forever begin
         @(negedge clk);
         dmm = 1'b0;
         if (!resetn) begin
            w    = -1;
            prev = 1'b0;
         end else begin
            if (smm && !prev) begin
               cur = '{aa, ab, ac, acc};
               got_q.push_back(cur);
               w = lat;
            end else if (smm && (cur !== tile_t'{aa, ab, ac, acc})) begin
               unstable++;
            end
            if (smm && w == 0) begin
               dmm = 1'b1;
               w   = -1;
            end else if (smm && w > 0) begin
               w--;
            end
            if (!smm) w = -1;
            prev = smm;
         end
      end
   end

   task automatic cfg(input int m, input int n, input int k,
                      input int a0, input int b0, input int c0,
                      input int s_a, input int s_b, input int s_c);
      nm = 8'(m);
      nn = 8'(n);
      nk = 8'(k);
      ba = 10'(a0);
      bb = 10'(b0);
      bc = 10'(c0);
      sa = 10'(s_a);
      sb = 10'(s_b);
      sc = 10'(s_c);
   endtask

   // Reference: tile (m,n,k) addresses from plain arithmetic mod 1024.
   task automatic build_exp();
      tile_t t;
      exp_q.delete();
      for (int m = 0; m < int'(nm); m++)
         for (int n = 0; n < int'(nn); n++)
            for (int k = 0; k < int'(nk); k++) begin
               t.a   = 10'(int'(ba) + m*int'(sa) + 4*k);
               t.b   = 10'(int'(bb) + n*int'(sb) + 4*k);
               t.c   = 10'(int'(bc) + m*int'(sc) + 4*n);
               t.acc = (k != 0);
               exp_q.push_back(t);
            end
   endtask

   task automatic check_tiles(input string tag);
      chk({tag, "_ntiles"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_a%0d", tag, i), got_q[i].a, exp_q[i].a);
         chk($sformatf("%s_b%0d", tag, i), got_q[i].b, exp_q[i].b);
         chk($sformatf("%s_c%0d", tag, i), got_q[i].c, exp_q[i].c);
         chk($sformatf("%s_acc%0d", tag, i), got_q[i].acc, exp_q[i].acc);
      end
   endtask

   task automatic wait_done(input string tag);
      int cyc = 0;
      while (done !== 1'b1 && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_done"}, done, 1'b1);
   endtask

   task automatic wait_tiles(input string tag, input int n);
      int cyc = 0;
      while (got_q.size() < n && cyc < 1000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_reach"}, (got_q.size() >= n), 1'b1);
   endtask

   // Full run from start to done release, with optional mid-run cfg noise.
   task automatic run_cmp(input string tag, input bit scramble);
      got_q.delete();
      build_exp();
      start = 1'b1;
      if (scramble) begin
         repeat (2) @(posedge clk);
         #1;
         cfg($urandom_range(0, 9), $urandom_range(0, 9),
             $urandom_range(0, 9), $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom);
      end
      wait_done(tag);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_tc"}, tc, exp_q.size());
      check_tiles(tag);
      start = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_doneclr"}, done, 1'b0);
   endtask

   initial begin : main
      int m, n, k;
      cfg(1, 1, 1, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_smm", smm, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_tc", tc, 0);
      chk("rst_addr", {aa, ab, ac, acc}, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      cfg(1, 1, 1, 'h0, 'h40, 'h80, 8, 8, 8);
      lat = 10;
      run_cmp("single", 1'b0);

      cfg(2, 2, 2, 'h0, 'h100, 'h200, 8, 8, 8);
      lat = 2;
      run_cmp("m2n2k2", 1'b0);

      cfg(2, 2, 0, 'h0, 'h100, 'h200, 8, 8, 8);
      got_q.delete();
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("zk_err", err, 1'b1);
      chk("zk_done", done, 1'b1);
      chk("zk_busy", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("zk_notiles", got_q.size(), 0);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("zk_errclr", err, 1'b0);
      chk("zk_doneclr", done, 1'b0);

      cfg(2, 2, 2, 'h0, 'h100, 'h200, 8, 8, 8);
      lat = 4;
      got_q.delete();
      start = 1'b1;
      wait_tiles("ab", 3);
      abort = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("ab_smm", smm, 1'b0);
      chk("ab_busy", busy, 1'b0);
      chk("ab_done", done, 1'b0);
      chk("ab_tc", tc, 2);
      repeat (3) @(posedge clk);
      #1;
      chk("ab_idle_tiles", got_q.size(), 3);
      run_cmp("ab_rerun", 1'b0);

      cfg(2, 2, 2, 'h10, 'h120, 'h230, 8, 8, 8);
      lat = 20;
      got_q.delete();
      start = 1'b1;
      wait_tiles("rs", 1);
      start = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("rs_busy", busy, 1'b1);
      chk("rs_nolaunch", got_q.size(), 1);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("rs_smm", smm, 1'b0);
      chk("rs_busy0", busy, 1'b0);
      chk("rs_tc", tc, 0);
      chk("rs_addr", {aa, ab, ac, acc}, 0);
      start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      chk("rs_idle", busy, 1'b0);

      cfg(1, 2, 1, 'h0, 'h40, 'h3FC, 8, 8, 8);
      lat = 1;
      run_cmp("cwrap", 1'b0);

      for (int r = 0; r < 6; r++) begin
         m = $urandom_range(1, 3);
         n = $urandom_range(1, 3);
         k = $urandom_range(1, 3);
         cfg(m, n, k, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom);
         lat = $urandom_range(0, 3);
         run_cmp($sformatf("rnd%0d", r), 1'b1);
      end

      chk("stable", unstable, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matmul_tile_sched.md
Name: matmul_tile_sched

Overview:
- Sequences the 4x4 matmul engine over a larger problem tiled into M x N x K blocks of MAT_MUL_SIZE.
- Sits between the cfg register block and the matmul unit. Generates `start_mat_mul`, per-tile A/B/C base addresses and an accumulate flag, and reports completion back to cfg/control.
- Sizes and addresses are latched at start, so cfg may be rewritten mid-run without effect.

Parameters:
- MAT_MUL_SIZE, 4, tile edge; address step between adjacent tiles along K/N.
- AWIDTH, 10, BRAM address width.
- DIM_WIDTH, 8, width of tile-count fields.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  level request from cfg
- abort  in  1  synchronous abort of the current run
- num_m_tiles  in  DIM_WIDTH  row tiles of A/C
- num_n_tiles  in  DIM_WIDTH  column tiles of B/C
- num_k_tiles  in  DIM_WIDTH  inner-dimension tiles
- base_a, base_b, base_c  in  AWIDTH each  matrix base addresses
- stride_a, stride_b, stride_c  in  AWIDTH each  address step per M-row of tiles (A, C) or per N-column of tiles (B)
- start_mat_mul  out  1  to matmul
- done_mat_mul  in  1  from matmul
- address_mat_a, address_mat_b, address_mat_c  out  AWIDTH each  current tile addresses
- accumulate  out  1  high when k != 0; C tile adds to the prior partial sum
- busy  out  1  run in progress
- done  out  1  run complete
- cfg_err  out  1  zero dimension seen at start
- tile_count  out  2*DIM_WIDTH+8  tiles completed in the current run

Behaviour:
- Reset is asynchronous and active-low on resetn. All outputs reset to 0, state IDLE.
- States: IDLE, LAUNCH, WAIT, GAP, DONE.
- IDLE:
  - On start=1: latch all sizes, bases and strides; clear counters and tile_count; set busy=1.
  - If any num_*_tiles==0: set cfg_err=1 and go to DONE. No tile is issued.
  - Otherwise load address_mat_a=base_a, address_mat_b=base_b, address_mat_c=base_c and go to LAUNCH.
- LAUNCH: start_mat_mul=1 (registered, asserted the cycle after entry); go to WAIT.
- WAIT:
  - start_mat_mul stays 1; addresses and accumulate stay stable.
  - On done_mat_mul=1: next cycle start_mat_mul=0, tile_count+1, go to GAP.
- GAP (exactly 1 cycle, start_mat_mul=0 so matmul resets its internal state). Advance indices with loop order k innermost, then n, then m:
  - k<K-1: k+1; A addr += MAT_MUL_SIZE; B addr += MAT_MUL_SIZE; C unchanged; accumulate=1.
  - k wraps, n<N-1: n+1; A addr = row_a; B addr = base_b + (n+1)*stride_b, computed incrementally from a column register; C addr += MAT_MUL_SIZE; accumulate=0.
  - k and n wrap, m<M-1: m+1; row_a += stride_a; row_c += stride_c; A=row_a; B=base_b; C=row_c; accumulate=0.
  - All wrap: go to DONE.
  - Otherwise go to LAUNCH.
- No multipliers; all addresses are incremental adds modulo 2^AWIDTH, and wrap-around is silent.
- DONE: busy=0, done=1, start_mat_mul=0. Hold until start=0, then go to IDLE and clear done and cfg_err.
- Simultaneous events:
  - start while busy: ignored.
  - abort in any non-IDLE state: next cycle start_mat_mul=0, busy=0, go to IDLE; done stays 0; tile_count holds its value.
  - abort has priority over done_mat_mul in the same cycle.
  - done_mat_mul outside WAIT: ignored.
- Total tiles = M*N*K; tile_count is wide enough for 255^3.

Optional Feature:
- Macro: TILE_SCHED_PERF_EN.
- With the macro:
  - Adds output perf_cycles [31:0]: counts cycles with busy=1, cleared at run start, saturates at 0xFFFFFFFF.
  - Adds output perf_wait [31:0]: counts cycles spent in WAIT.
- Without the macro: neither port nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package: state encoding constants (IDLE=0, LAUNCH=1, WAIT=2, GAP=3, DONE=4), the MAT_MUL_SIZE and AWIDTH defines already used by matmul/cfg, and the tile_count width constant.
- One natural sub-module: tile_addr_gen, holding the index counters and row/column address registers. It takes an advance strobe and emits addresses, accumulate and a last flag. The FSM stays in the top module.

Test Plan:
- M=N=K=1, bases 0/0x40/0x80, done_mat_mul 10 cycles after start_mat_mul:
  - exactly one start_mat_mul pulse train with A=0x00, B=0x40, C=0x80, accumulate=0;
  - done=1, tile_count=1;
  - done clears after start=0.
- M=2, N=2, K=2, strides 8/8/8, bases 0/0x100/0x200: 8 tiles issued in order.
  - A sequence: 0,4,0,4,8,12,8,12.
  - B sequence: 0x100,0x104,0x108,0x10C,0x100,0x104,0x108,0x10C.
  - C sequence: 0x200 (x2), 0x204 (x2), 0x208 (x2), 0x20C (x2).
  - accumulate sequence: 0,1,0,1,0,1,0,1.
  - At least one low cycle of start_mat_mul between tiles.
- num_k_tiles=0 at start: no start_mat_mul; cfg_err=1 and done=1 within 2 cycles.
- abort asserted during WAIT of tile 3 of 8: start_mat_mul low next cycle, busy=0, done=0, tile_count=2; a fresh start then runs all 8 tiles.
- resetn driven low mid-WAIT (asynchronous, between clock edges): all outputs 0 immediately; start toggling while busy has no effect.
- base_c=0x3FC, N=2, stride irrelevant: second C address wraps to 0x000.
